lin_sched: RTL

LIN_SCHED -- requirements
Module: lin_sched

---
 rtl/lin_pkg.sv | 27 ++
 rtl/lin_sched_table.sv | 36 +++
 rtl/lin_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lin_pkg.sv
// Shared types and constants for the LIN schedule-table engine.
//   PID_W         : LIN protected-identifier width carried per slot.
//   SLOT_DLY_MAX  : storage width of the slot delay field; the engine's
//                   DLY_W parameter must not exceed it.
//   sched_state_e : scheduler FSM states.
//   slot_t        : one schedule-table entry {en, pid, delay}.
package lin_pkg;

    localparam int PID_W        = 6;
    localparam int SLOT_DLY_MAX = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_TX,
        S_RESP,
        S_DELAY
    } sched_state_e;

    typedef struct packed {
        logic                    en;
        logic [PID_W-1:0]        pid;
        logic [SLOT_DLY_MAX-1:0] delay;
    } slot_t;

endpackage

// File: rtl/lin_sched_table.sv
// Schedule-table register file: one synchronous write port, one
// combinational read port. Synchronous reset clears every slot.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   we_i, waddr_i          : write strobe and slot index
//   wen_i, wpid_i, wdly_i  : slot enable, PID and post-frame delay
//   raddr_i / rdata_o      : read index and combinational slot contents
module lin_sched_table
    import lin_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int DLY_W     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] waddr_i,
    input  logic                         wen_i,
    input  logic [PID_W-1:0]             wpid_i,
    input  logic [DLY_W-1:0]             wdly_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] raddr_i,
    output slot_t                        rdata_o
);

    slot_t mem_q [NUM_SLOTS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= '{en: wen_i, pid: wpid_i, delay: SLOT_DLY_MAX'(wdly_i)};
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lin_sched.sv
// LIN commander schedule engine. Walks the schedule table from slot 0 to
// cfg_last, skipping disabled slots, issues one frame per enabled slot to
// the commander, waits for TX and response completion, then holds off the
// commander for the slot's delay before moving on.
//
// Ports:
//   sys_clk, rst        : clock, synchronous active-high reset
//   run                 : schedule runs while high (stop honoured at DELAY exit)
//   cfg_we/addr/pid/delay/en : table write port
//   cfg_last            : index of the last slot in the schedule
//   err_clr             : clears timeout_err
//   lin_busy, comm_tx_done, resp_busy : commander/responder status
//   start, pid          : commander frame request
//   inter_tx_delay      : commander hold-off during the post-frame delay
//   slot_idx, frame_cnt, sched_busy, timeout_err : status
//
// Build option: define LIN_SCHED_TIMEOUT_EN to add a TX/RESP timeout of
// TMO_CYCLES cycles that sets the sticky timeout_err and forces the delay.
module lin_sched
    import lin_pkg::*;
#(
    parameter int NUM_SLOTS  = 8,
    parameter int DLY_W      = 16,
    parameter int TMO_CYCLES = 1000
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr,
    input  logic [PID_W-1:0]             cfg_pid,
    input  logic [DLY_W-1:0]             cfg_delay,
    input  logic                         cfg_en,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_last,
    input  logic                         err_clr,
    input  logic                         lin_busy,
    input  logic                         comm_tx_done,
    input  logic                         resp_busy,
    output logic                         start,
    output logic [PID_W-1:0]             pid,
    output logic                         inter_tx_delay,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
    output logic [15:0]                  frame_cnt,
    output logic                         sched_busy,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
    logic [IDX_W-1:0] skip_q, skip_d;        // consecutive disabled slots seen
    logic             start_q, start_d;
    logic [PID_W-1:0] pid_q, pid_d;
    logic             itd_q, itd_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;          // delay latched at FETCH
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             go_dly;
    logic             tmo_hit;
    logic             tmo_fire;
    logic [IDX_W-1:0] idx_next;
    slot_t            rd;

    lin_sched_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .DLY_W     (DLY_W)
    ) u_table (
        .clk_i   (sys_clk),
        .rst_i   (rst),
        .we_i    (cfg_we),
        .waddr_i (cfg_addr),
        .wen_i   (cfg_en),
        .wpid_i  (cfg_pid),
        .wdly_i  (cfg_delay),
        .raddr_i (slot_idx_q),
        .rdata_o (rd)
    );

    if (DLY_W < SLOT_DLY_MAX) begin : g_pad
        logic unused_dly_hi;
        assign unused_dly_hi = |rd.delay[SLOT_DLY_MAX-1:DLY_W];
    end

    // cfg_last is sampled live; an index already beyond it wraps too.
    assign idx_next = (slot_idx_q >= cfg_last) ? '0 : slot_idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        slot_idx_d  = slot_idx_q;
        skip_d      = skip_q;
        start_d     = start_q;
        pid_d       = pid_q;
        itd_d       = itd_q;
        frame_cnt_d = frame_cnt_q;
        dly_d       = dly_q;
        cnt_d       = cnt_q;
        go_dly      = 1'b0;
        tmo_fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    slot_idx_d = '0;
                    skip_d     = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rd.en) begin
                    pid_d   = rd.pid;
                    dly_d   = rd.delay[DLY_W-1:0];
                    start_d = 1'b1;
                    skip_d  = '0;
                    state_d = S_ISSUE;
                end else begin
                    slot_idx_d = idx_next;
                    skip_d     = skip_q + 1'b1;
                    // This is skip number cfg_last+1: whole table is idle.
                    if (skip_q >= cfg_last) state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (lin_busy) begin
                    start_d = 1'b0;
                    state_d = S_TX;
                end
            end
            S_TX: begin
                if (comm_tx_done) begin
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    go_dly   = 1'b1;
                end
            end
            S_RESP: begin
                if (!resp_busy && !lin_busy) begin
                    go_dly = 1'b1;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    go_dly   = 1'b1;
                end
            end
            S_DELAY: begin
                // Exit on the cycle the count would reach 0, so a delay of D
                // occupies max(D,1) cycles.
                if (cnt_q <= DLY_W'(1)) begin
                    itd_d       = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    slot_idx_d  = idx_next;
                    skip_d      = '0;
                    state_d     = run ? S_FETCH : S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go_dly) begin
            cnt_d   = dly_q;
            itd_d   = 1'b1;
            state_d = S_DELAY;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_idx_q  <= '0;
            skip_q      <= '0;
            start_q     <= 1'b0;
            pid_q       <= '0;
            itd_q       <= 1'b0;
            frame_cnt_q <= '0;
            dly_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_idx_q  <= slot_idx_d;
            skip_q      <= skip_d;
            start_q     <= start_d;
            pid_q       <= pid_d;
            itd_q       <= itd_d;
            frame_cnt_q <= frame_cnt_d;
            dly_q       <= dly_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

`ifdef LIN_SCHED_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        terr_q, terr_d;

    assign tmo_hit = (tmo_q == 32'(TMO_CYCLES - 1));

    always_comb begin
        tmo_d  = '0;
        terr_d = terr_q;
        // Counter restarts whenever TX or RESP is entered.
        if ((state_q == S_TX || state_q == S_RESP) && state_d == state_q)
            tmo_d = tmo_q + 32'd1;
        if (tmo_fire)     terr_d = 1'b1;   // set wins over clear
        else if (err_clr) terr_d = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tmo_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    logic unused_tmo;
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_tmo  = err_clr ^ tmo_fire ^ (TMO_CYCLES == 0);
`endif

    assign start          = start_q;
    assign pid            = pid_q;
    assign inter_tx_delay = itd_q;
    assign slot_idx       = slot_idx_q;
    assign frame_cnt      = frame_cnt_q;
    assign sched_busy     = busy_q;

endmodule
